mesi_isc_broad_arb: RTL and testbench



---
 rtl/mesi_isc_pkg.sv | 23 ++
 rtl/mesi_isc_broad_arb_if.sv | 52 +++++
 rtl/mesi_isc_rr_pick4.sv | 23 ++
 rtl/mesi_isc_broad_arb.sv | 107 ++++++++++
 tb/tb_mesi_isc_broad_arb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared types and defaults for the MESI ISC broadcast path.
// States, CPU count and default field widths.
package mesi_isc_pkg;

  localparam int CPU_CNT = 4;
  localparam int ADDR_W  = 32;
  localparam int TYPE_W  = 2;
  localparam int ID_W    = 5;
  localparam int STALL_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_FULL
  } state_t;

  function automatic logic [CPU_CNT-1:0] onehot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mesi_isc_broad_arb_if.sv
// Request/FIFO-write bundle for the broadcast arbiter.
// master = CPUs + FIFO side, slave = arbiter.
interface mesi_isc_broad_arb_if
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = TYPE_W,
  parameter int BROAD_ID_WIDTH   = ID_W,
  parameter int STALL_CNT_WIDTH  = STALL_W
);

  logic [CPU_CNT-1:0]                  breq_valid_array_i;
  logic [CPU_CNT*ADDR_WIDTH-1:0]       breq_addr_array_i;
  logic [CPU_CNT*BROAD_TYPE_WIDTH-1:0] breq_type_array_i;
  logic                                fifo_status_full_i;
  logic [CPU_CNT-1:0]                  breq_ack_array_o;
  logic                                broad_fifo_wr_o;
  logic [ADDR_WIDTH-1:0]               broad_addr_o;
  logic [BROAD_TYPE_WIDTH-1:0]         broad_type_o;
  logic [1:0]                          broad_cpu_id_o;
  logic [BROAD_ID_WIDTH-1:0]           broad_id_o;
  logic [STALL_CNT_WIDTH-1:0]          stall_cnt_o;

  modport master (
    output breq_valid_array_i,
    output breq_addr_array_i,
    output breq_type_array_i,
    output fifo_status_full_i,
    input  breq_ack_array_o,
    input  broad_fifo_wr_o,
    input  broad_addr_o,
    input  broad_type_o,
    input  broad_cpu_id_o,
    input  broad_id_o,
    input  stall_cnt_o
  );

  modport slave (
    input  breq_valid_array_i,
    input  breq_addr_array_i,
    input  breq_type_array_i,
    input  fifo_status_full_i,
    output breq_ack_array_o,
    output broad_fifo_wr_o,
    output broad_addr_o,
    output broad_type_o,
    output broad_cpu_id_o,
    output broad_id_o,
    output stall_cnt_o
  );

endinterface

// File: rtl/mesi_isc_rr_pick4.sv
// Four-way round-robin pick: first set request at or after ptr.
// Pure combinational; grant is don't-care when any is low.
module mesi_isc_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // Scan farthest-first so the nearest set bit wins.
  always_comb begin
    grant = ptr;
    idx   = ptr;
    any   = |req;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/mesi_isc_broad_arb.sv
// Broadcast write-side arbiter: round-robin over four CPUs,
// stamps a rolling ID and issues one FIFO write per grant.
module mesi_isc_broad_arb
  import mesi_isc_pkg::*;
#(
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = TYPE_W,
  parameter int BROAD_ID_WIDTH   = ID_W,
  parameter int STALL_CNT_WIDTH  = STALL_W
) (
  input logic              clk,
  input logic              rst,
  mesi_isc_broad_arb_if.slave bus
);

  state_t                      state;
  logic [1:0]                  rr_ptr;
  logic [1:0]                  grant;
  logic                        any;
  logic                        full;
  logic                        do_issue;
  logic [BROAD_ID_WIDTH-1:0]   id_cnt;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic [BROAD_TYPE_WIDTH-1:0] sel_type;

  logic [CPU_CNT-1:0]          ack_q;
  logic                        wr_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [BROAD_TYPE_WIDTH-1:0] type_q;
  logic [1:0]                  cpu_q;
  logic [BROAD_ID_WIDTH-1:0]   bid_q;
  logic [STALL_CNT_WIDTH-1:0]  stall_q;

  assign full = bus.fifo_status_full_i;

  mesi_isc_rr_pick4 u_pick (
    .req   (bus.breq_valid_array_i),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (any)
  );

  // ISSUE is never an arbitration point: one issue per two cycles.
  always_comb begin
    do_issue = any && !full && (state != ISSUE);
  end

  always_comb begin
    sel_addr = '0;
    sel_type = '0;
    for (int i = 0; i < CPU_CNT; i++) begin
      if (grant == 2'(i)) begin
        sel_addr = bus.breq_addr_array_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_type = bus.breq_type_array_i[i*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id_cnt  <= '0;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      type_q  <= '0;
      cpu_q   <= '0;
      bid_q   <= '0;
      stall_q <= '0;
    end else begin
      wr_q  <= do_issue;
      ack_q <= do_issue ? onehot4(grant) : '0;
      if (do_issue) begin
        addr_q <= sel_addr;
        type_q <= sel_type;
        cpu_q  <= grant;
        bid_q  <= id_cnt;
        id_cnt <= id_cnt + 1'b1;
        rr_ptr <= grant + 2'd1;
      end
      if (state == WAIT_FULL && full && !(&stall_q))
        stall_q <= stall_q + 1'b1;
      unique case (state)
        IDLE: begin
          if (do_issue) state <= ISSUE;
          else if (any) state <= WAIT_FULL;
        end
        ISSUE: state <= IDLE;
        WAIT_FULL: begin
          if (do_issue) state <= ISSUE;
          else if (!any) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.breq_ack_array_o = ack_q;
  assign bus.broad_fifo_wr_o  = wr_q;
  assign bus.broad_addr_o     = addr_q;
  assign bus.broad_type_o     = type_q;
  assign bus.broad_cpu_id_o   = cpu_q;
  assign bus.broad_id_o       = bid_q;
  assign bus.stall_cnt_o      = stall_q;

endmodule

// File: tb/tb_mesi_isc_broad_arb.sv
// Scoreboard bench for mesi_isc_broad_arb: directed requests,
// expected issues queued, monitor pops on each FIFO write.
module tb_mesi_isc_broad_arb;

  localparam int AW = 32;
  localparam int TW = 2;
  localparam int IW = 5;
  localparam int SW = 8;

  typedef struct {
    logic [3:0]    ack;
    logic [AW-1:0] addr;
    logic [TW-1:0] typ;
    logic [1:0]    cpu;
    logic [IW-1:0] id;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  mesi_isc_broad_arb_if #(
    .ADDR_WIDTH(AW), .BROAD_TYPE_WIDTH(TW),
    .BROAD_ID_WIDTH(IW), .STALL_CNT_WIDTH(SW)
  ) bus ();

  mesi_isc_broad_arb #(
    .ADDR_WIDTH(AW), .BROAD_TYPE_WIDTH(TW),
    .BROAD_ID_WIDTH(IW), .STALL_CNT_WIDTH(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requester model: drop valid at the edge that samples ack.
  task automatic tick();
    logic [3:0] a;
    @(posedge clk);
    a = bus.breq_ack_array_o;
    #1;
    bus.breq_valid_array_i = bus.breq_valid_array_i & ~a;
  endtask

  task automatic post(input int c, input logic [AW-1:0] a,
                      input logic [TW-1:0] t);
    bus.breq_addr_array_i[c*AW +: AW] = a;
    bus.breq_type_array_i[c*TW +: TW] = t;
    bus.breq_valid_array_i[c] = 1'b1;
  endtask

  task automatic expect_issue(input int c, input logic [AW-1:0] a,
                              input logic [TW-1:0] t,
                              input logic [IW-1:0] id);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << c;
    e.ack = oh;
    e.addr = a;
    e.typ = t;
    e.cpu = 2'(c);
    e.id = id;
    q.push_back(e);
  endtask

  task automatic drain(input string nm, input int bound,
                       output int used);
    used = 0;
    while (bus.breq_valid_array_i != 4'b0 && used < bound) begin
      tick();
      used++;
    end
    chk(nm, 32'(bus.breq_valid_array_i), 32'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk("pulse_reset_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
    tick();
    rst = 1'b1;
  endtask

  // Monitor: every write pops one expectation; ack is quiet otherwise.
  initial begin
    exp_t e;
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.broad_fifo_wr_o) begin
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got cpu %0d id %0d expected no write",
                     bus.broad_cpu_id_o, bus.broad_id_o);
          end else begin
            e = q.pop_front();
            if (bus.breq_ack_array_o !== e.ack ||
                bus.broad_addr_o !== e.addr ||
                bus.broad_type_o !== e.typ ||
                bus.broad_cpu_id_o !== e.cpu ||
                bus.broad_id_o !== e.id) begin
              n_fail++;
              $display("FAIL issue: got ack=%b addr=%h type=%0d cpu=%0d id=%0d expected ack=%b addr=%h type=%0d cpu=%0d id=%0d",
                       bus.breq_ack_array_o, bus.broad_addr_o,
                       bus.broad_type_o, bus.broad_cpu_id_o,
                       bus.broad_id_o, e.ack, e.addr, e.typ,
                       e.cpu, e.id);
            end
          end
          n_checks++;
          if (prev_wr) begin
            n_fail++;
            $display("FAIL wr_spacing: got back-to-back write expected gap");
          end
        end else begin
          n_checks++;
          if (bus.breq_ack_array_o !== 4'b0) begin
            n_fail++;
            $display("FAIL ack_without_wr: got %b expected 0000",
                     bus.breq_ack_array_o);
          end
        end
        prev_wr = bus.broad_fifo_wr_o;
      end else begin
        prev_wr = 1'b0;
      end
    end
  end

  initial begin
    int used;
    n_checks = 0;
    n_fail = 0;

    rst = 1'b0;
    bus.breq_valid_array_i = 4'($urandom);
    bus.breq_addr_array_i = {$urandom, $urandom, $urandom, $urandom};
    bus.breq_type_array_i = 8'($urandom);
    bus.fifo_status_full_i = 1'($urandom);
    repeat (3) tick();
    chk("rst_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
    chk("rst_ack", 32'(bus.breq_ack_array_o), 32'h0);
    chk("rst_addr", bus.broad_addr_o, 32'h0);
    chk("rst_type", 32'(bus.broad_type_o), 32'h0);
    chk("rst_cpu", 32'(bus.broad_cpu_id_o), 32'h0);
    chk("rst_id", 32'(bus.broad_id_o), 32'h0);
    chk("rst_stall", 32'(bus.stall_cnt_o), 32'h0);

    bus.breq_valid_array_i = 4'b0;
    bus.fifo_status_full_i = 1'b0;
    rst = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_no_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
    end

    // Single request from CPU2.
    expect_issue(2, 32'h1000_0040, 2'b01, 5'd0);
    post(2, 32'h1000_0040, 2'b01);
    tick();
    chk("single_wr", 32'(bus.broad_fifo_wr_o), 32'h1);
    chk("single_ack", 32'(bus.breq_ack_array_o), 32'h4);
    drain("single_drain", 4, used);
    chk("single_cycles", 32'(used), 32'd1);

    // All four contend from reset.
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      expect_issue(c, 32'h3000_0000 + 32'(c) * 32'h100, 2'(c), 5'(c));
      post(c, 32'h3000_0000 + 32'(c) * 32'h100, 2'(c));
    end
    drain("contend_drain", 20, used);
    chk("contend_cycles", 32'(used), 32'd8);

    // CPU0 and CPU3 with rr_ptr back at 0.
    expect_issue(0, 32'h3100_0000, 2'b10, 5'd4);
    expect_issue(3, 32'h3100_0300, 2'b11, 5'd5);
    post(0, 32'h3100_0000, 2'b10);
    post(3, 32'h3100_0300, 2'b11);
    drain("pair_drain", 10, used);
    chk("pair_cycles", 32'(used), 32'd4);

    // FIFO full with CPU1 pending for ten stalled cycles.
    bus.fifo_status_full_i = 1'b1;
    post(1, 32'h5000_0010, 2'b10);
    tick();
    repeat (10) tick();
    chk("full_no_wr", 32'(bus.broad_fifo_wr_o), 32'h0);
    chk("full_stall", 32'(bus.stall_cnt_o), 32'd10);
    expect_issue(1, 32'h5000_0010, 2'b10, 5'd6);
    bus.fifo_status_full_i = 1'b0;
    tick();
    chk("unfull_wr", 32'(bus.broad_fifo_wr_o), 32'h1);
    drain("unfull_drain", 4, used);
    chk("stall_hold", 32'(bus.stall_cnt_o), 32'd10);

    // 33 issues from a fresh ID counter.
    pulse_reset();
    chk("reset_stall_clr", 32'(bus.stall_cnt_o), 32'd0);
    for (int i = 0; i < 33; i++) begin
      expect_issue(i % 4, 32'h2000_0000 + 32'(i) * 4, 2'(i), 5'(i));
      post(i % 4, 32'h2000_0000 + 32'(i) * 4, 2'(i));
      drain("wrap_drain", 4, used);
    end

    // Stall counter saturation.
    bus.fifo_status_full_i = 1'b1;
    post(2, 32'h6000_0080, 2'b00);
    tick();
    repeat (300) tick();
    chk("stall_sat", 32'(bus.stall_cnt_o), 32'd255);
    expect_issue(2, 32'h6000_0080, 2'b00, 5'd1);
    bus.fifo_status_full_i = 1'b0;
    drain("sat_drain", 4, used);
    chk("sat_hold", 32'(bus.stall_cnt_o), 32'd255);

    // Reset lands in the middle of an issue cycle.
    post(3, 32'h4000_00c0, 2'b11);
    tick();
    chk("midrst_wr_before", 32'(bus.broad_fifo_wr_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_wr_drop", 32'(bus.broad_fifo_wr_o), 32'h0);
    chk("midrst_ack_drop", 32'(bus.breq_ack_array_o), 32'h0);
    tick();
    tick();
    chk("midrst_valid_kept", 32'(bus.breq_valid_array_i), 32'h8);
    expect_issue(3, 32'h4000_00c0, 2'b11, 5'd0);
    rst = 1'b1;
    tick();
    chk("midrst_reissue", 32'(bus.broad_fifo_wr_o), 32'h1);
    drain("midrst_drain", 4, used);

    repeat (3) tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
